spinn_aer_if_dump_multi: RTL

Multi-channel, parametrised successor to the single-channel SpiNNaker-link packet dumper. It sits between the AER-side mapper outputs and the SpiNNaker link transmitters. It gives each channel a registered one-entry output stage and a runtime-programmable stall threshold. When SpiNNaker back-pressures a channel for too long, that channel drops packets until the link recovers. Dropped packets are optionally counted per channel.

---
 rtl/spinn_aer_if_dump_multi_pkg.sv | 26 ++
 rtl/spinn_aer_dump_chan.sv | 169 ++++++++++++++++
 rtl/spinn_aer_if_dump_multi.sv | 51 +++++
 3 files changed

// File: rtl/spinn_aer_if_dump_multi_pkg.sv
// Shared definitions for the multi-channel SpiNNaker-link packet dumper:
// FSM state encodings, default widths and the stall-expiry decision helper.
package spinn_aer_if_dump_multi_pkg;

    // FSM state encoding
    localparam int STATE_BITS = 1;
    localparam logic [0:0] IDLE_ST = 1'b0;
    localparam logic [0:0] DUMP_ST = 1'b1;

    // Default widths
    localparam int DEF_PKT_BITS      = 72;
    localparam int DEF_CTR_BITS      = 8;
    localparam int DEF_DROP_CNT_BITS = 16;

    // A busy cycle ends the stall window when the countdown is on its last
    // step, or when it already sits at zero but dumping has since been enabled.
    function automatic logic stall_expired(
        input logic busy,
        input logic ctr_is_one,
        input logic ctr_is_zero,
        input logic thresh_nonzero
    );
        return busy & (ctr_is_one | (ctr_is_zero & thresh_nonzero));
    endfunction

endpackage

// File: rtl/spinn_aer_dump_chan.sv
// One packet channel of the SpiNNaker-link dumper: registered one-entry
// output stage, stall countdown, IDLE/DUMP state machine and (when
// SPINN_AER_DUMP_STATS_EN is defined) a saturating dropped-packet counter.
module spinn_aer_dump_chan
    import spinn_aer_if_dump_multi_pkg::*;
#(
    parameter int PKT_BITS      = DEF_PKT_BITS,
    parameter int CTR_BITS      = DEF_CTR_BITS,
    parameter int DROP_CNT_BITS = DEF_DROP_CNT_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     go,
    input  logic [CTR_BITS-1:0]      dump_thresh,
    input  logic                     drop_clr,
    output logic                     dump_mode,
    output logic [DROP_CNT_BITS-1:0] dropped_cnt,
    input  logic [PKT_BITS-1:0]      mpkt_data,
    input  logic                     mpkt_vld,
    output logic                     mpkt_rdy,
    output logic [PKT_BITS-1:0]      ipkt_data,
    output logic                     ipkt_vld,
    input  logic                     ipkt_rdy
);

    localparam logic [CTR_BITS-1:0] CTR_ZERO = {CTR_BITS{1'b0}};
    localparam logic [CTR_BITS-1:0] CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};
    localparam logic [CTR_BITS-1:0] CTR_ONES = {CTR_BITS{1'b1}};

    logic [STATE_BITS-1:0] state_r;
    logic [STATE_BITS-1:0] state_nxt_s;
    logic [CTR_BITS-1:0]   ctr_r;
    logic                  vld_r;
    logic [PKT_BITS-1:0]   data_r;

    logic in_dump_s;
    logic busy_s;
    logic rdy_s;
    logic take_s;
    logic enter_dump_s;
    logic exit_dump_s;

    // Handshake and stall decode for the current cycle
    always_comb begin
        in_dump_s    = (state_r == DUMP_ST);
        busy_s       = vld_r & ~ipkt_rdy;
        // In DUMP everything is swallowed; in IDLE accept whenever the output
        // register frees up this cycle, or whenever flushing.
        rdy_s        = in_dump_s | ~vld_r | ipkt_rdy | ~go;
        take_s       = mpkt_vld & rdy_s;
        exit_dump_s  = in_dump_s & ipkt_rdy;
        if (!in_dump_s) begin
            enter_dump_s = stall_expired(busy_s,
                                         (ctr_r == CTR_ONE),
                                         (ctr_r == CTR_ZERO),
                                         (dump_thresh != CTR_ZERO));
        end else begin
            enter_dump_s = 1'b0;
        end
    end

    // Next-state logic of the IDLE/DUMP machine
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE_ST: begin
                if (enter_dump_s) begin
                    state_nxt_s = DUMP_ST;
                end else begin
                    state_nxt_s = IDLE_ST;
                end
            end
            DUMP_ST: begin
                // The packet taken in the exit cycle is still dropped; the
                // machine forwards again from the following cycle.
                if (exit_dump_s) begin
                    state_nxt_s = IDLE_ST;
                end else begin
                    state_nxt_s = DUMP_ST;
                end
            end
            default: begin
                state_nxt_s = IDLE_ST;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE_ST;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Stall countdown: reloads on every non-busy cycle, so a threshold change
    // only takes effect at the next reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_r <= CTR_ONES;
        end else if (!busy_s) begin
            ctr_r <= dump_thresh;
        end else if (ctr_r != CTR_ZERO) begin
            ctr_r <= ctr_r - CTR_ONE;
        end else begin
            ctr_r <= ctr_r;
        end
    end

    // One-entry output register; the held packet is discarded on DUMP entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r  <= 1'b0;
            data_r <= {PKT_BITS{1'b0}};
        end else if (in_dump_s || enter_dump_s) begin
            vld_r  <= 1'b0;
        end else if (take_s && go) begin
            vld_r  <= 1'b1;
            data_r <= mpkt_data;
        end else if (ipkt_rdy) begin
            vld_r  <= 1'b0;
        end else begin
            vld_r  <= vld_r;
        end
    end

`ifdef SPINN_AER_DUMP_STATS_EN
    logic [1:0]               drop_inc_s;
    logic [DROP_CNT_BITS:0]   drop_sum_s;
    logic [DROP_CNT_BITS-1:0] cnt_nxt_s;
    logic [DROP_CNT_BITS-1:0] cnt_r;

    // Drops this cycle: the held packet on DUMP entry plus any input taken
    // while dumping; clear has priority over a same-cycle drop.
    always_comb begin
        drop_inc_s = {1'b0, enter_dump_s} + {1'b0, in_dump_s & take_s};
        drop_sum_s = {1'b0, cnt_r} + {{(DROP_CNT_BITS-1){1'b0}}, drop_inc_s};
        if (drop_clr) begin
            cnt_nxt_s = {DROP_CNT_BITS{1'b0}};
        end else if (drop_sum_s[DROP_CNT_BITS]) begin
            cnt_nxt_s = {DROP_CNT_BITS{1'b1}};
        end else begin
            cnt_nxt_s = drop_sum_s[DROP_CNT_BITS-1:0];
        end
    end

    // Saturating dropped-packet counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {DROP_CNT_BITS{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign dropped_cnt = cnt_r;
`else
    logic unused_stats_s;
    assign unused_stats_s = drop_clr;
    assign dropped_cnt    = {DROP_CNT_BITS{1'b0}};
`endif

    assign dump_mode = (state_r == DUMP_ST);
    assign mpkt_rdy  = rdy_s;
    assign ipkt_vld  = vld_r;
    assign ipkt_data = data_r;

endmodule

// File: rtl/spinn_aer_if_dump_multi.sv
// Multi-channel SpiNNaker-link packet dumper. Each of NUM_CH independent
// channels forwards mapper packets through a registered stage and dumps them
// when the link back-pressures longer than dump_thresh cycles.
// Define SPINN_AER_DUMP_STATS_EN to build the per-channel drop counters;
// otherwise dropped_cnt reads zero and drop_clr is ignored.
module spinn_aer_if_dump_multi
    import spinn_aer_if_dump_multi_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int PKT_BITS      = DEF_PKT_BITS,
    parameter int CTR_BITS      = DEF_CTR_BITS,
    parameter int DROP_CNT_BITS = DEF_DROP_CNT_BITS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CH-1:0]               go,
    input  logic [CTR_BITS-1:0]             dump_thresh,
    input  logic                            drop_clr,
    output logic [NUM_CH-1:0]               dump_mode,
    output logic [NUM_CH*DROP_CNT_BITS-1:0] dropped_cnt,
    input  logic [NUM_CH*PKT_BITS-1:0]      mpkt_data,
    input  logic [NUM_CH-1:0]               mpkt_vld,
    output logic [NUM_CH-1:0]               mpkt_rdy,
    output logic [NUM_CH*PKT_BITS-1:0]      ipkt_data,
    output logic [NUM_CH-1:0]               ipkt_vld,
    input  logic [NUM_CH-1:0]               ipkt_rdy
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        spinn_aer_dump_chan #(
            .PKT_BITS      (PKT_BITS),
            .CTR_BITS      (CTR_BITS),
            .DROP_CNT_BITS (DROP_CNT_BITS)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .go          (go[g]),
            .dump_thresh (dump_thresh),
            .drop_clr    (drop_clr),
            .dump_mode   (dump_mode[g]),
            .dropped_cnt (dropped_cnt[g*DROP_CNT_BITS +: DROP_CNT_BITS]),
            .mpkt_data   (mpkt_data[g*PKT_BITS +: PKT_BITS]),
            .mpkt_vld    (mpkt_vld[g]),
            .mpkt_rdy    (mpkt_rdy[g]),
            .ipkt_data   (ipkt_data[g*PKT_BITS +: PKT_BITS]),
            .ipkt_vld    (ipkt_vld[g]),
            .ipkt_rdy    (ipkt_rdy[g])
        );
    end

endmodule
